// File: rtl/vga_bounce_box_if.sv
// Signal bundle between the VGA timing generator, the bounce-box colour stage and the pins.
// The master drives the timing/pixel inputs and reads back colour and the delayed syncs.
interface vga_bounce_box_if;
   logic        hsync_in;
   logic        vsync_in;
   logic        blank_n_in;
   logic        disp_enable;
   logic [31:0] xpix;
   logic [31:0] ypix;
   logic        r;
   logic        g;
   logic        b;
   logic        hsync_out;
   logic        vsync_out;
   logic        blank_n_out;
   logic        frame_tick;

   modport master (
      output hsync_in, vsync_in, blank_n_in, disp_enable, xpix, ypix,
      input  r, g, b, hsync_out, vsync_out, blank_n_out, frame_tick
   );

   modport slave (
      input  hsync_in, vsync_in, blank_n_in, disp_enable, xpix, ypix,
      output r, g, b, hsync_out, vsync_out, blank_n_out, frame_tick
   );
endinterface

// File: rtl/vga_bounce_box.sv
// Pixel-colour stage: draws a box that moves STEP pixels per frame and bounces off the edges.
// Optional macro BOUNCE_COLOR_CYCLE_EN makes the box colour advance on every bounce.
module vga_bounce_box #(
   parameter int unsigned H_DISP    = 1280,
   parameter int unsigned V_DISP    = 1024,
   parameter int unsigned BOX_W     = 64,
   parameter int unsigned BOX_H     = 64,
   parameter int unsigned STEP      = 4,
   parameter logic        VS_ACTIVE = 1'b0,
   parameter logic [2:0]  BG_RGB    = 3'b001,
   parameter logic [2:0]  BOX_RGB   = 3'b110
) (
   input logic             clk,
   input logic             rst,
   vga_bounce_box_if.slave bus
);

   localparam logic [31:0] X_MAX  = 32'(H_DISP - BOX_W);
   localparam logic [31:0] Y_MAX  = 32'(V_DISP - BOX_H);
   localparam logic [31:0] STEP_W = 32'(STEP);
   localparam logic [31:0] BOX_WW = 32'(BOX_W);
   localparam logic [31:0] BOX_HW = 32'(BOX_H);

   // bit 0 = moving left, bit 1 = moving up
   typedef enum logic [1:0] {DR = 2'b00, DL = 2'b01, UR = 2'b10, UL = 2'b11} state_t;

   state_t      state;
   logic [31:0] box_x, box_y, nx, ny;
   logic        flip_x, flip_y;
   logic        vs_d, frame_evt, tick_p0;
   logic [2:0]  box_rgb;

   logic        hs_p0, vs_p0, bl_p0, de_p0, in_x_p0, in_y_p0;
   logic [2:0]  rgb_p1;
   logic        hs_p1, vs_p1, bl_p1;

`ifdef BOUNCE_COLOR_CYCLE_EN
   logic [2:0]  box_col;
   assign box_rgb = box_col;
`else
   assign box_rgb = BOX_RGB;
`endif

   assign frame_evt = (bus.vsync_in == VS_ACTIVE) && (vs_d != VS_ACTIVE);

   always_comb begin
      nx     = box_x;
      ny     = box_y;
      flip_x = 1'b0;
      flip_y = 1'b0;
      if (!state[0]) begin
         if (box_x + STEP_W >= X_MAX) begin
            nx     = X_MAX;
            flip_x = 1'b1;
         end else nx = box_x + STEP_W;
      end else if (box_x <= STEP_W) begin
         nx     = '0;
         flip_x = 1'b1;
      end else nx = box_x - STEP_W;
      if (!state[1]) begin
         if (box_y + STEP_W >= Y_MAX) begin
            ny     = Y_MAX;
            flip_y = 1'b1;
         end else ny = box_y + STEP_W;
      end else if (box_y <= STEP_W) begin
         ny     = '0;
         flip_y = 1'b1;
      end else ny = box_y - STEP_W;
   end

   // Position only changes on the vsync-entry cycle, so a frame always sees one latched box.
   always_ff @(posedge clk) begin
      vs_d <= bus.vsync_in;
      if (rst) begin
         state   <= DR;
         box_x   <= '0;
         box_y   <= '0;
         tick_p0 <= 1'b0;
`ifdef BOUNCE_COLOR_CYCLE_EN
         box_col <= 3'b001;
`endif
      end else begin
         tick_p0 <= frame_evt;
         if (frame_evt) begin
            box_x <= nx;
            box_y <= ny;
            state <= state_t'({state[1] ^ flip_y, state[0] ^ flip_x});
`ifdef BOUNCE_COLOR_CYCLE_EN
            if (flip_x || flip_y) box_col <= (box_col == 3'b111) ? 3'b001 : box_col + 3'b001;
`endif
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hs_p0   <= ~VS_ACTIVE;
         vs_p0   <= ~VS_ACTIVE;
         bl_p0   <= 1'b0;
         de_p0   <= 1'b0;
         in_x_p0 <= 1'b0;
         in_y_p0 <= 1'b0;
         rgb_p1  <= 3'b000;
         hs_p1   <= ~VS_ACTIVE;
         vs_p1   <= ~VS_ACTIVE;
         bl_p1   <= 1'b0;
      end else begin
         // stage 1: register timing, evaluate box membership
         hs_p0   <= bus.hsync_in;
         vs_p0   <= bus.vsync_in;
         bl_p0   <= bus.blank_n_in;
         de_p0   <= bus.disp_enable;
         in_x_p0 <= (bus.xpix >= box_x) && (bus.xpix < box_x + BOX_WW);
         in_y_p0 <= (bus.ypix >= box_y) && (bus.ypix < box_y + BOX_HW);
         // stage 2: colour select, syncs kept aligned with it
         rgb_p1  <= !de_p0 ? 3'b000 : (in_x_p0 && in_y_p0) ? box_rgb : BG_RGB;
         hs_p1   <= hs_p0;
         vs_p1   <= vs_p0;
         bl_p1   <= bl_p0;
      end
   end

   assign bus.r           = rgb_p1[2];
   assign bus.g           = rgb_p1[1];
   assign bus.b           = rgb_p1[0];
   assign bus.hsync_out   = hs_p1;
   assign bus.vsync_out   = vs_p1;
   assign bus.blank_n_out = bl_p1;
   assign bus.frame_tick  = tick_p0;

endmodule
